// File: rtl/mc_main_fsm.sv
// mc_main_fsm: main control FSM of the multi-cycle MIPS core.
// Sequences fetch/decode/execute/memory/writeback, holds in memory states
// until mem_ready, and a watchdog aborts any access stalled too long.
// Optional feature macro: MC_FSM_BNE_EN (adds bne as a branch opcode).
module mc_main_fsm #(
  parameter int unsigned OP_WIDTH     = 6,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned TO_CNT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_WIDTH-1:0] op,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                iord,
  output logic                memwrite,
  output logic                irwrite,
  output logic                pcwrite,
  output logic                branch,
  output logic                bne,
  output logic [1:0]          pcsrc,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          aluop,
  output logic                regdst,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                illegal_op,
  output logic                err,
  output logic [3:0]          state
);

  // Last counter value before the watchdog fires (counter counts from 0).
  localparam int unsigned TO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam bit          WD_EN   = (MEM_TIMEOUT != 0);

  localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'b000010);
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_BNE   = OP_WIDTH'(6'b000101);
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'b101011);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  state_e                  state_q, state_d;
  logic [TO_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    wait_st_c;
  logic                    timeout_c;

  // State, watchdog counter and sticky error registers; synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state, watchdog and control decode from the current state.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    bne        = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    illegal_op = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        if (op == OP_LW || op == OP_SW) begin
          state_d = S_MEMADR;
        end else if (op == OP_RTYPE) begin
          state_d = S_EXEC;
        end else if (op == OP_BEQ) begin
          state_d = S_BRANCH;
`ifdef MC_FSM_BNE_EN
        end else if (op == OP_BNE) begin
          state_d = S_BRANCH;
`endif
        end else if (op == OP_ADDI) begin
          state_d = S_ADDIEX;
        end else if (op == OP_J) begin
          state_d = S_JUMP;
        end else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = (op == OP_BEQ);
`ifdef MC_FSM_BNE_EN
        bne     = (op == OP_BNE);
`else
        bne     = 1'b0;
`endif
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Watchdog: count stalled cycles in waiting states; mem_ready wins.
    wait_st_c = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                (state_q == S_MEMWR);
    timeout_c = WD_EN && wait_st_c && !mem_ready &&
                (cnt_q == TO_CNT_WIDTH'(TO_LAST));
    if (WD_EN && wait_st_c && !mem_ready && !timeout_c) begin
      cnt_d = cnt_q + TO_CNT_WIDTH'(1);
    end else begin
      cnt_d = '0;
    end
    err_d = err_q | timeout_c;
    if (timeout_c) begin
      state_d = S_FETCH;
    end

    // While reset is held, no enable may fire; selects show FETCH values.
    if (!rst) begin
      mem_req    = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      bne        = 1'b0;
      pcsrc      = 2'b00;
      alusrca    = 1'b0;
      alusrcb    = 2'b01;
      aluop      = 2'b00;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign err   = err_q;
  assign state = 4'(state_q);

endmodule

// File: tb/tb_mc_main_fsm.sv
// Testbench for mc_main_fsm: table-driven vectors plus hand-built
// watchdog sequences, checked through an expected-value queue.
module tb_mc_main_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       bne;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal_op;
  } ctl_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;
    ctl_t       ctl;
    logic       err;
    string      name;
  } vec_t;

  // Expected control words, field order as in ctl_t:
  // mreq iord mw irw pcw br bne | pcsrc | asa | asb | aluop | rdst m2r rw ill
  localparam ctl_t C_RST  = 18'b0000000_00_0_01_00_0000;
  localparam ctl_t C_FW   = 18'b1000000_00_0_01_00_0000;
  localparam ctl_t C_FR   = 18'b1001100_00_0_01_00_0000;
  localparam ctl_t C_DEC  = 18'b0000000_00_0_11_00_0000;
  localparam ctl_t C_DECI = 18'b0000000_00_0_11_00_0001;
  localparam ctl_t C_MADR = 18'b0000000_00_1_10_00_0000;
  localparam ctl_t C_MRD  = 18'b1100000_00_0_00_00_0000;
  localparam ctl_t C_MWB  = 18'b0000000_00_0_00_00_0110;
  localparam ctl_t C_MWR  = 18'b1110000_00_0_00_00_0000;
  localparam ctl_t C_EXEC = 18'b0000000_00_1_00_10_0000;
  localparam ctl_t C_ALWB = 18'b0000000_00_0_00_00_1010;
  localparam ctl_t C_BEQ  = 18'b0000010_01_1_00_01_0000;
  localparam ctl_t C_BNE  = 18'b0000001_01_1_00_01_0000;
  localparam ctl_t C_AIEX = 18'b0000000_00_1_10_00_0000;
  localparam ctl_t C_AIWB = 18'b0000000_00_0_00_00_0010;
  localparam ctl_t C_JMP  = 18'b0000100_10_0_00_00_0000;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req, iord, memwrite, irwrite, pcwrite, branch, bne;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic       alusrca, regdst, memtoreg, regwrite, illegal_op, err;
  logic [3:0] state;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  mc_main_fsm #(
    .OP_WIDTH    (6),
    .MEM_TIMEOUT (16),
    .TO_CNT_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .iord      (iord),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .pcwrite   (pcwrite),
    .branch    (branch),
    .bne       (bne),
    .pcsrc     (pcsrc),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .illegal_op(illegal_op),
    .err       (err),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [5:0] o, input logic m,
                     input logic [3:0] s, input ctl_t c, input logic e,
                     input string n);
    vec_t v;
    v.rst = r; v.op = o; v.mr = m; v.st = s; v.ctl = c; v.err = e; v.name = n;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs (1 time unit after posedge), check at negedge.
  task automatic apply(input vec_t v);
    vec_t e;
    ctl_t act;
    logic bad;
    rst       = v.rst;
    op        = v.op;
    mem_ready = v.mr;
    exp_q.push_back(v);
    #4;
    e   = exp_q.pop_front();
    act = {mem_req, iord, memwrite, irwrite, pcwrite, branch, bne, pcsrc,
           alusrca, alusrcb, aluop, regdst, memtoreg, regwrite, illegal_op};
    bad = 1'b0;
    n_vec++;
    if (state !== e.st) begin
      $display("FAIL %s state: got %0d want %0d", e.name, state, e.st);
      bad = 1'b1;
    end
    if (act !== e.ctl) begin
      $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
      bad = 1'b1;
    end
    if (err !== e.err) begin
      $display("FAIL %s err: got %b want %b", e.name, err, e.err);
      bad = 1'b1;
    end
    if (bad) n_bad++;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r, input logic [5:0] o, input logic m,
                      input logic [3:0] s, input ctl_t c, input logic e,
                      input string n);
    vec_t v;
    v.rst = r; v.op = o; v.mr = m; v.st = s; v.ctl = c; v.err = e; v.name = n;
    apply(v);
  endtask

  initial begin
    rst = 1'b0; op = '0; mem_ready = 1'b0;
    @(posedge clk);
    #1;

    add(0, OP_R,    0, 4'd0,  C_RST,  0, "reset");
    // lw: 0,1,2,3,4 then back to FETCH
    add(1, OP_LW,   1, 4'd0,  C_FR,   0, "lw_fetch");
    add(1, OP_LW,   1, 4'd1,  C_DEC,  0, "lw_decode");
    add(1, OP_LW,   1, 4'd2,  C_MADR, 0, "lw_memadr");
    add(1, OP_LW,   1, 4'd3,  C_MRD,  0, "lw_memrd");
    add(1, OP_LW,   1, 4'd4,  C_MWB,  0, "lw_memwb");
    // R-type
    add(1, OP_R,    1, 4'd0,  C_FR,   0, "r_fetch");
    add(1, OP_R,    1, 4'd1,  C_DEC,  0, "r_decode");
    add(1, OP_R,    1, 4'd6,  C_EXEC, 0, "r_exec");
    add(1, OP_R,    1, 4'd7,  C_ALWB, 0, "r_aluwb");
    // addi
    add(1, OP_ADDI, 1, 4'd0,  C_FR,   0, "addi_fetch");
    add(1, OP_ADDI, 1, 4'd1,  C_DEC,  0, "addi_decode");
    add(1, OP_ADDI, 1, 4'd9,  C_AIEX, 0, "addi_ex");
    add(1, OP_ADDI, 1, 4'd10, C_AIWB, 0, "addi_wb");
    // FETCH stalled 3 cycles, then beq
    add(1, OP_BEQ,  0, 4'd0,  C_FW,   0, "fetch_wait1");
    add(1, OP_BEQ,  0, 4'd0,  C_FW,   0, "fetch_wait2");
    add(1, OP_BEQ,  0, 4'd0,  C_FW,   0, "fetch_wait3");
    add(1, OP_BEQ,  1, 4'd0,  C_FR,   0, "fetch_ready");
    add(1, OP_BEQ,  1, 4'd1,  C_DEC,  0, "beq_decode");
    add(1, OP_BEQ,  1, 4'd8,  C_BEQ,  0, "beq_branch");
    // jump
    add(1, OP_J,    1, 4'd0,  C_FR,   0, "j_fetch");
    add(1, OP_J,    1, 4'd1,  C_DEC,  0, "j_decode");
    add(1, OP_J,    1, 4'd11, C_JMP,  0, "j_jump");
    // unsupported opcode
    add(1, OP_BAD,  1, 4'd0,  C_FR,   0, "ill_fetch");
    add(1, OP_BAD,  1, 4'd1,  C_DECI, 0, "ill_decode");
    // bne, feature dependent
    add(1, OP_BNE,  1, 4'd0,  C_FR,   0, "bne_fetch");
`ifdef MC_FSM_BNE_EN
    add(1, OP_BNE,  1, 4'd1,  C_DEC,  0, "bne_decode");
    add(1, OP_BNE,  1, 4'd8,  C_BNE,  0, "bne_branch");
`else
    add(1, OP_BNE,  1, 4'd1,  C_DECI, 0, "bne_decode_ill");
`endif
    // sw interrupted by reset while waiting in MEMWR
    add(1, OP_SW,   1, 4'd0,  C_FR,   0, "sw_fetch");
    add(1, OP_SW,   1, 4'd1,  C_DEC,  0, "sw_decode");
    add(1, OP_SW,   1, 4'd2,  C_MADR, 0, "sw_memadr");
    add(1, OP_SW,   0, 4'd5,  C_MWR,  0, "sw_memwr1");
    add(1, OP_SW,   0, 4'd5,  C_MWR,  0, "sw_memwr2");
    add(0, OP_SW,   0, 4'd5,  C_RST,  0, "rst_in_memwr");
    add(0, OP_SW,   0, 4'd0,  C_RST,  0, "rst_hold1");
    add(0, OP_SW,   0, 4'd0,  C_RST,  0, "rst_hold2");
    add(1, OP_SW,   0, 4'd0,  C_FW,   0, "rst_release");

    foreach (vecs[i]) apply(vecs[i]);

    // mem_ready on the 16th stalled cycle wins over the watchdog.
    step(1, OP_SW, 1, 4'd0, C_FR,   0, "wd_win_fetch");
    step(1, OP_SW, 1, 4'd1, C_DEC,  0, "wd_win_decode");
    step(1, OP_SW, 1, 4'd2, C_MADR, 0, "wd_win_memadr");
    for (int i = 0; i < 15; i++) step(1, OP_SW, 0, 4'd5, C_MWR, 0, "wd_win_wait");
    step(1, OP_SW, 1, 4'd5, C_MWR,  0, "wd_win_ready");
    step(1, OP_SW, 0, 4'd0, C_FW,   0, "wd_win_after");

    // mem_ready stuck low: abort after 16 waiting cycles in MEMWR.
    step(1, OP_SW, 1, 4'd0, C_FR,   0, "wd_to_fetch");
    step(1, OP_SW, 1, 4'd1, C_DEC,  0, "wd_to_decode");
    step(1, OP_SW, 1, 4'd2, C_MADR, 0, "wd_to_memadr");
    for (int i = 0; i < 16; i++) step(1, OP_SW, 0, 4'd5, C_MWR, 0, "wd_to_wait");
    step(1, OP_SW, 0, 4'd0, C_FW,   1, "wd_to_abort");

    // err is sticky while the FSM keeps running; reset clears it.
    step(1, OP_J,  1, 4'd0,  C_FR,  1, "sticky_fetch");
    step(1, OP_J,  1, 4'd1,  C_DEC, 1, "sticky_decode");
    step(1, OP_J,  1, 4'd11, C_JMP, 1, "sticky_jump");
    step(0, OP_J,  0, 4'd0,  C_RST, 1, "err_rst");
    step(1, OP_J,  0, 4'd0,  C_FW,  0, "err_cleared");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_main_fsm.md
Name: mc_main_fsm

Overview:
Main control state machine for the multi-cycle MIPS core. It sequences fetch, decode, execute, memory and writeback over several cycles. It drives the register file write enable and its write-port muxes, plus the ALU, PC and memory-interface controls. It holds at memory states until a memory-ready handshake arrives, and a watchdog aborts any stalled access.

Parameters:
OP_WIDTH, 6, opcode field width (instr[31:26])
MEM_TIMEOUT, 16, max consecutive mem_ready-low cycles in a waiting state before abort; 0 disables the watchdog
TO_CNT_WIDTH, 8, watchdog counter width; must satisfy MEM_TIMEOUT < 2**TO_CNT_WIDTH

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
op  in  OP_WIDTH  opcode from the instruction register
mem_ready  in  1  memory completed the current access this cycle
mem_req  out  1  memory access request
iord  out  1  address mux: 0=PC, 1=ALUOut
memwrite  out  1  memory write enable
irwrite  out  1  instruction register load
pcwrite  out  1  unconditional PC load
branch  out  1  PC load if ALU zero=1
bne  out  1  PC load if ALU zero=0
pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
alusrca  out  1  0=PC, 1=regfile rd1
alusrcb  out  2  00=rd2, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
aluop  out  2  00=add, 01=sub, 10=funct decode
regdst  out  1  regfile a3 select: 0=rt, 1=rd
memtoreg  out  1  regfile wd3 select: 0=ALUOut, 1=data reg
regwrite  out  1  regfile write enable (drives we)
illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
err  out  1  sticky watchdog abort flag
state  out  4  current state, for debug

Behaviour:
- State register, 4 bits. Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 go to FETCH on the next clock.
- Reset: when rst=0 at a rising edge, state<=FETCH, watchdog counter<=0, err<=0. While rst=0, every enable (mem_req, memwrite, irwrite, pcwrite, branch, bne, regwrite, illegal_op) is forced to 0. Mux selects take FETCH values. Reset mid-operation abandons the instruction with no write.
- Outputs decode combinationally from state. Any output not listed below is 0.
- FETCH: mem_req=1, alusrcb=01. irwrite=1 and pcwrite=1 only in a cycle where mem_ready=1, which also moves to DECODE. Otherwise hold.
- DECODE: alusrcb=11. Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other op -> FETCH, with illegal_op=1 in this cycle
- MEMADR: alusrca=1, alusrcb=10. Next state MEMRD if op=100011, otherwise MEMWR.
- MEMRD: mem_req=1, iord=1. Moves to MEMWB when mem_ready=1.
- MEMWB: memtoreg=1, regwrite=1. Next state FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1, held throughout the wait. Moves to FETCH when mem_ready=1.
- EXEC: alusrca=1, aluop=10. Next state ALUWB.
- ALUWB: regdst=1, regwrite=1. Next state FETCH.
- BRANCH: alusrca=1, aluop=01, pcsrc=01. branch=1 for op 000100, bne=1 for op 000101. Next state FETCH.
- ADDIEX: alusrca=1, alusrcb=10. Next state ADDIWB.
- ADDIWB: regwrite=1. Next state FETCH.
- JUMP: pcsrc=10, pcwrite=1. Next state FETCH.
- Latency with mem_ready always 1, counted in cycles from FETCH back to FETCH:
  - lw 5
  - sw, R-type, addi 4
  - beq, bne, j 3
- Watchdog:
  - Waiting states are FETCH, MEMRD and MEMWR.
  - The counter increments on each cycle spent in a waiting state with mem_ready=0. It clears on mem_ready=1 or on leaving the state.
  - On the clock edge that ends the MEM_TIMEOUT-th consecutive waiting cycle: state<=FETCH, err<=1, counter<=0. No write enable is asserted on that abort edge beyond the current state's decode.
  - err stays set until reset. The FSM keeps running after an abort.
  - mem_ready=1 in the same cycle as the timeout wins: a normal transition occurs and err is not set.

Optional Feature:
MC_FSM_BNE_EN. Defined: op 000101 in DECODE -> BRANCH, and BRANCH asserts bne=1 with branch=0. Undefined: op 000101 is illegal (illegal_op pulse, return to FETCH), and bne is tied to 0.

Test Plan:
- rst=0 for 3 cycles in MEMWR with memwrite=1, then rst=1 -> memwrite=0 while in reset; state=0, err=0 after release.
- lw (op=100011), mem_ready=1 -> states 0,1,2,3,4,0; regwrite=1 only in state 4 with memtoreg=1, regdst=0.
- R-type (op=000000), then addi (op=001000) -> regwrite=1 in ALUWB with regdst=1; in ADDIWB with regdst=0 and memtoreg=0; 4 cycles each.
- FETCH with mem_ready low for 3 cycles, then high -> irwrite and pcwrite pulse exactly once, on the 4th cycle; DECODE follows.
- MEM_TIMEOUT=16, sw, mem_ready stuck at 0 in MEMWR -> after 16 waiting cycles err=1 and state=0; memwrite high for all 16 cycles then low.
- op=000101 -> with MC_FSM_BNE_EN: states 0,1,8,0 with bne=1. Without the macro: states 0,1,0 with a single illegal_op pulse in DECODE.
